// File: rtl/uart_disp_pkg.sv
// uart_disp_pkg: shared types and constants for the UART hex display buffer.
// Holds the pop FSM state enum, the digit field layout, the slot geometry
// and the carriage-return byte used by the optional clear-on-CR feature.
package uart_disp_pkg;

  // Pop sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // One display digit is {en, hex[3:0], dp_n}.
  localparam int DIGIT_W = 6;
  localparam int EN_BIT  = 5;
  localparam int HEX_MSB = 4;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;

  // Four byte slots, two digits each; slot 0 is the newest byte.
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 8;
  localparam int COUNT_W   = 3;

  localparam logic [7:0] CR_BYTE = 8'h0D;

  // Packs the digit fields into their bit positions.
  function automatic logic [DIGIT_W-1:0] make_digit(input logic       en,
                                                    input logic [3:0] hex,
                                                    input logic       dp_n);
    logic [DIGIT_W-1:0] d;
    d                  = '0;
    d[EN_BIT]          = en;
    d[HEX_MSB:HEX_LSB] = hex;
    d[DP_BIT]          = dp_n;
    return d;
  endfunction

endpackage

// File: rtl/uart_disp_slots.sv
// uart_disp_slots: four-byte shift register plus saturating fill count.
// A capture shifts every slot one place towards the oldest end and loads the
// new byte into slot 0; a clear zeroes slots and count and beats a capture.
// Next-state values are exported so the parent can register display digits
// on the same edge as the slot update.
module uart_disp_slots
  import uart_disp_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        capture,
  input  logic [SLOT_W-1:0]           din,
  output logic [NUM_SLOTS*SLOT_W-1:0] slots_nxt,
  output logic [COUNT_W-1:0]          count_nxt,
  output logic [COUNT_W-1:0]          count
);

  logic [NUM_SLOTS*SLOT_W-1:0] slots_q, slots_d;
  logic [COUNT_W-1:0]          count_q, count_d;

  // Next slot contents and fill count: clear wins, capture shifts and counts up to full.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    slots_d = slots_q;
    count_d = count_q;
    if (clr) begin
      slots_d = '0;
      count_d = '0;
    end else if (capture) begin
      slots_d = {slots_q[(NUM_SLOTS-1)*SLOT_W-1:0], din};
      if (count_q != COUNT_W'(NUM_SLOTS)) begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  // Slot and count registers; reset dominates clear and capture.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      // NOTE: the slot storage is reset explicitly because unfilled slots must read as zero; a large RAM would not be reset this way.
      slots_q <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
    end
  end

  assign slots_nxt = slots_d;
  assign count_nxt = count_d;
  assign count     = count_q;

endmodule

// File: rtl/uart_hex_display_buffer.sv
// uart_hex_display_buffer: pops bytes from a UART receive FIFO and shows the
// last four as eight hex digits (I7..I0, I0 rightmost, newest byte on I1:I0).
// A three-state sequencer (IDLE, POP, GAP) issues one rd_uart strobe per byte
// and optionally idles PACE_CYCLES cycles after each pop. Digit outputs are
// registered and change on the same edge that captures the byte.
// Optional build macro: UART_DISP_CR_CLEAR_EN -- when defined, a popped 0x0D
// clears the display instead of being shown.
module uart_hex_display_buffer
  import uart_disp_pkg::*;
#(
  parameter bit LEADING_BLANK = 1'b1,
  parameter int PACE_CYCLES   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [7:0]         r_data,
  output logic               rd_uart,
  input  logic               hold,
  input  logic               clr,
  output logic [DIGIT_W-1:0] I0,
  output logic [DIGIT_W-1:0] I1,
  output logic [DIGIT_W-1:0] I2,
  output logic [DIGIT_W-1:0] I3,
  output logic [DIGIT_W-1:0] I4,
  output logic [DIGIT_W-1:0] I5,
  output logic [DIGIT_W-1:0] I6,
  output logic [DIGIT_W-1:0] I7,
  output logic [2:0]         byte_count
);

  // Gap counter starts at PACE_CYCLES-1 and counts down to zero inclusive.
  localparam logic [7:0] PACE_LAST = (PACE_CYCLES > 0) ? 8'(PACE_CYCLES - 1) : 8'd0;

  // Digit shown for an empty slot after reset or clear.
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = make_digit(~LEADING_BLANK, 4'h0, 1'b1);

  state_e     state_q, state_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       rd_uart_q;
  logic       capture;
  logic       clear_req;

  logic [NUM_SLOTS*SLOT_W-1:0] slots_nxt;
  logic [COUNT_W-1:0]          count_nxt;
  logic [COUNT_W-1:0]          count_q;

  logic [DIGIT_W-1:0] digits_d [2*NUM_SLOTS];
  logic [DIGIT_W-1:0] digits_q [2*NUM_SLOTS];

  // Sequencer next state: hold and FIFO-empty only gate the start of a pop.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_empty && !hold) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        if (PACE_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = PACE_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; rd_uart is registered and high exactly while in POP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      rd_uart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      rd_uart_q <= (state_d == ST_POP);
    end
  end

  // The FIFO head is taken on the same edge that ends the POP cycle, even if
  // rx_empty was raised meanwhile.
  assign capture = (state_q == ST_POP);
  assign rd_uart = rd_uart_q;

  // Display clear request: external clr, plus a popped CR when that feature is built in.
  always_comb begin
    clear_req = clr;
`ifdef UART_DISP_CR_CLEAR_EN
    if (capture && (r_data == CR_BYTE)) begin
      clear_req = 1'b1;
    end
`else
    clear_req = clr;
`endif
  end

  uart_disp_slots u_slots (
    .clk       (clk),
    .reset     (reset),
    .clr       (clear_req),
    .capture   (capture),
    .din       (r_data),
    .slots_nxt (slots_nxt),
    .count_nxt (count_nxt),
    .count     (count_q)
  );

  // Format the next slot contents into digits; only I0 carries the point, and only when a byte is held.
  always_comb begin : format_digits
    logic       filled;
    logic [7:0] slot_byte;
    logic       en;
    filled    = 1'b0;
    slot_byte = '0;
    en        = 1'b0;
    for (int i = 0; i < 2*NUM_SLOTS; i++) begin
      digits_d[i] = BLANK_DIGIT;
    end
    for (int k = 0; k < NUM_SLOTS; k++) begin
      filled          = (int'(count_nxt) > k);
      slot_byte       = filled ? slots_nxt[k*SLOT_W +: SLOT_W] : 8'h00;
      en              = filled | ~LEADING_BLANK;
      digits_d[2*k+1] = make_digit(en, slot_byte[7:4], 1'b1);
      digits_d[2*k]   = make_digit(en, slot_byte[3:0], !((k == 0) && (count_nxt != '0)));
    end
  end

  // Digit output registers, updated on the capture/clear edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2*NUM_SLOTS; i++) begin
        digits_q[i] <= BLANK_DIGIT;
      end
    end else begin
      for (int i = 0; i < 2*NUM_SLOTS; i++) begin
        digits_q[i] <= digits_d[i];
      end
    end
  end

  assign I0         = digits_q[0];
  assign I1         = digits_q[1];
  assign I2         = digits_q[2];
  assign I3         = digits_q[3];
  assign I4         = digits_q[4];
  assign I5         = digits_q[5];
  assign I6         = digits_q[6];
  assign I7         = digits_q[7];
  assign byte_count = count_q;

endmodule

// File: doc/uart_hex_display_buffer.md
UART_HEX_DISPLAY_BUFFER -- requirements
Module: uart_hex_display_buffer

Interface
REQ-001 Parameter LEADING_BLANK, default 1: 1 = digits of unfilled byte slots are blanked; 0 = they show "0".
REQ-002 Parameter PACE_CYCLES, default 0: minimum idle cycles after each pop before the next pop (0..255).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_empty  in  1  receive FIFO empty flag.
REQ-006 r_data  in  8  receive FIFO head byte, valid while rx_empty=0.
REQ-007 rd_uart  out  1  FIFO pop strobe; one cycle per byte.
REQ-008 hold  in  1  level; 1 = no new pops start.
REQ-009 clr  in  1  one-cycle synchronous display clear.
REQ-010 I0..I7  out  6 each  display digit {en, hex[3:0], dp_n}. I0 is the rightmost digit. dp_n=0 lights the point.
REQ-011 byte_count  out  3  number of bytes held, 0..4.

Function
REQ-012 The FSM SHALL have states IDLE, POP and GAP.
REQ-013 IDLE SHALL go to POP when rx_empty=0 and hold=0; otherwise it SHALL stay in IDLE.
REQ-014 In POP, rd_uart SHALL be 1 for exactly that one cycle, and r_data SHALL be captured on the same edge.
REQ-015 POP SHALL go to GAP when PACE_CYCLES>0, else to IDLE.
REQ-016 GAP SHALL hold rd_uart=0 for PACE_CYCLES cycles, then go to IDLE.
REQ-017 Throughput SHALL be one byte per 2+PACE_CYCLES cycles.
REQ-018 Capture SHALL shift the four byte slots left by one.
- New byte: I1 = high nibble, I0 = low nibble.
- Oldest byte (I7:I6) is discarded.
REQ-019 byte_count SHALL increment on capture and saturate at 4.
REQ-020 Digit en SHALL be 1 for digits of filled slots; unfilled slots take en=~LEADING_BLANK with hex=0.
REQ-021 dp_n SHALL be 0 only on I0, and only when byte_count>0; all other digits SHALL have dp_n=1.
REQ-022 Digit outputs SHALL be registered and update the cycle after capture.
REQ-023 clr SHALL zero all slots and byte_count and SHALL NOT change FSM state.
REQ-024 clr in the POP cycle SHALL take priority: the byte is still popped but discarded, and byte_count=0.
REQ-025 hold asserted during POP or GAP SHALL NOT abort them; it only blocks the IDLE->POP transition.
REQ-026 If rx_empty=1 is observed in POP (FIFO misuse), rd_uart SHALL still pulse and the byte SHALL be captured as-is.

Reset
REQ-027 reset SHALL win over clr and capture.
REQ-028 On reset the block SHALL enter IDLE with rd_uart=0, byte_count=0 and all slots zero.
REQ-029 After reset every digit SHALL read {~LEADING_BLANK, 4'h0, 1}.
REQ-030 Reset asserted mid-POP SHALL drop rd_uart in the next cycle; the byte is not captured.

Configuration
REQ-031 With UART_DISP_CR_CLEAR_EN defined, a popped byte 0x0D SHALL act as clr (slots and count zeroed) and SHALL NOT be displayed.
REQ-032 Without UART_DISP_CR_CLEAR_EN, 0x0D SHALL be shown as "0D" like any other byte.

Structure
REQ-033 Package uart_disp_pkg SHALL hold:
- FSM state enum
- DIGIT_W=6
- field positions EN=5, HEX=4:1, DP=0
- NUM_SLOTS=4
- CR_BYTE=8'h0D
REQ-034 Sub-module uart_disp_slots SHALL hold the 4x8 slot shift register and byte_count (shift, clear, saturate).
REQ-035 The top level SHALL hold the FSM, the pace counter and the digit formatting.

Verification
REQ-036 Reset, LEADING_BLANK=1 -> all Ix=6'b000001, byte_count=0, rd_uart=0.
REQ-037 FIFO holds 0xA5, PACE_CYCLES=0 -> rd_uart one cycle; next cycle I1={1,A,1}, I0={1,5,0}, byte_count=1.
REQ-038 Bytes 0x11,0x22,0x33,0x44,0x55 -> I7..I0 show 2,2,3,3,4,4,5,5; byte_count=4; second pop one cycle after the first POP's IDLE.
REQ-039 PACE_CYCLES=3, two bytes queued -> rd_uart pulses exactly 5 cycles apart; hold=1 in IDLE -> no pulses until released.
REQ-040 clr in the POP cycle of byte 0x7E -> rd_uart=1, slots stay zero, byte_count=0.
REQ-041 Byte 0x0D with UART_DISP_CR_CLEAR_EN -> display cleared; without it -> I1={1,0,1}, I0={1,D,0}.
